kcpsm_io_bank: RTL and testbench

- Parametrised PicoBlaze (KCPSM6) register interface; next generation of the Nexys4 board I/O block.
- Provides N binary-decoded input ports, M write-strobed output registers and optional output readback.
- Adds a masked, edge-triggered, multi-source interrupt controller with a write-1-to-clear pending register, replacing the single-request interrupt flip-flop.
- Sits between the KCPSM6 port bus and the board/Rojobot logic: buttons, switches, LEDs, 7-segment digits, motor control and bot status.

---
 rtl/kcpsm_io_bank.sv | 103 ++++++++++
 tb/tb_kcpsm_io_bank.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/kcpsm_io_bank.sv
// KCPSM6 port-bus register bank: input read mux, output registers and a masked edge-triggered interrupt controller.
// Optional output readback at 0x80+n is enabled by defining KCPSM_IO_READBACK_EN.
module kcpsm_io_bank #(
  parameter int         NUM_IN        = 16,
  parameter int         NUM_OUT       = 16,
  parameter int         NUM_IRQ       = 4,
  parameter logic [7:0] OUT_RESET_VAL = 8'h00
) (
  input  logic                 sysclk,
  input  logic                 sysreset,
  input  logic [7:0]           port_id,
  input  logic                 write_strobe,
  input  logic                 read_strobe,
  input  logic [7:0]           io_data_in,
  output logic [7:0]           io_data_out,
  output logic                 interrupt,
  input  logic                 interrupt_ack,
  input  logic [NUM_IN*8-1:0]  in_ports,
  output logic [NUM_OUT*8-1:0] out_ports,
  input  logic [NUM_IRQ-1:0]   irq_req
);

  localparam logic [7:0] ADDR_MASK = 8'hFC;
  localparam logic [7:0] ADDR_PEND = 8'hFD;
  localparam logic [7:0] ADDR_RAW  = 8'hFE;

  logic [NUM_IRQ-1:0] sync1, sync2, prev, arm;
  logic [NUM_IRQ-1:0] mask, pend, act;
  logic [NUM_IRQ-1:0] rise_det, mask_next, pend_next, act_next;
  logic [1:0]         fill;
  logic               irq_next;
  logic [7:0]         rd_data;

  // Reads have no side effects, so the read qualifier is intentionally ignored.
  logic unused;
  assign unused = read_strobe;

  function automatic logic [7:0] zext(input logic [NUM_IRQ-1:0] v);
    logic [7:0] r;
    r = '0;
    r[NUM_IRQ-1:0] = v;
    return r;
  endfunction

  // A source only produces an edge once it has been seen low after reset,
  // so a line held high through reset never raises a spurious request.
  always_comb begin
    rise_det  = sync2 & ~prev & arm;
    mask_next = mask;
    pend_next = pend;
    if (write_strobe && port_id == ADDR_MASK) mask_next = io_data_in[NUM_IRQ-1:0];
    if (write_strobe && port_id == ADDR_PEND) pend_next = pend & ~io_data_in[NUM_IRQ-1:0];
    pend_next = pend_next | rise_det;
    act_next  = pend_next & mask_next;
    if (|(act_next & ~act))  irq_next = 1'b1;
    else if (interrupt_ack)  irq_next = 1'b0;
    else                     irq_next = interrupt;
  end

  always_comb begin
    rd_data = 8'h00;
    for (int n = 0; n < NUM_IN; n++)
      if (port_id == 8'(n)) rd_data = in_ports[8*n +: 8];
`ifdef KCPSM_IO_READBACK_EN
    for (int n = 0; n < NUM_OUT; n++)
      if (port_id == 8'(8'h80 + n)) rd_data = out_ports[8*n +: 8];
`endif
    if (port_id == ADDR_MASK) rd_data = zext(mask);
    if (port_id == ADDR_PEND) rd_data = zext(pend);
    if (port_id == ADDR_RAW)  rd_data = zext(sync2);
  end

  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      sync1       <= '0;
      sync2       <= '0;
      prev        <= '0;
      arm         <= '0;
      fill        <= '0;
      mask        <= '0;
      pend        <= '0;
      act         <= '0;
      interrupt   <= 1'b0;
      io_data_out <= 8'h00;
      out_ports   <= {NUM_OUT{OUT_RESET_VAL}};
    end else begin
      sync1 <= irq_req;
      sync2 <= sync1;
      prev  <= sync2;
      // sync2 holds a real sample of irq_req only from the second cycle after reset
      if (fill != 2'd2) fill <= fill + 2'd1;
      if (fill == 2'd2) arm <= arm | ~sync2;
      mask        <= mask_next;
      pend        <= pend_next;
      act         <= act_next;
      interrupt   <= irq_next;
      io_data_out <= rd_data;
      for (int n = 0; n < NUM_OUT; n++)
        if (write_strobe && port_id == 8'(n)) out_ports[8*n +: 8] <= io_data_in;
    end
  end

endmodule

// File: tb/tb_kcpsm_io_bank.sv
// Directed self-checking bench for kcpsm_io_bank with default parameters.
module tb_kcpsm_io_bank;

  logic         sysclk = 1'b0;
  logic         sysreset;
  logic [7:0]   port_id;
  logic         write_strobe;
  logic         read_strobe;
  logic [7:0]   io_data_in;
  logic [7:0]   io_data_out;
  logic         interrupt;
  logic         interrupt_ack;
  logic [127:0] in_ports;
  logic [127:0] out_ports;
  logic [3:0]   irq_req;

  logic [127:0] exp_out;
  logic [7:0]   exp_rb;
  int           n_checks = 0;
  int           n_fail   = 0;

  kcpsm_io_bank dut (
    .sysclk        (sysclk),
    .sysreset      (sysreset),
    .port_id       (port_id),
    .write_strobe  (write_strobe),
    .read_strobe   (read_strobe),
    .io_data_in    (io_data_in),
    .io_data_out   (io_data_out),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .in_ports      (in_ports),
    .out_ports     (out_ports),
    .irq_req       (irq_req)
  );

  always #5 sysclk = ~sysclk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    port_id = addr; io_data_in = data; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] addr);
    port_id = addr;
    tick();
  endtask

  initial begin
    sysreset = 1'b1; write_strobe = 1'b1; port_id = 8'h00; io_data_in = 8'hFF;
    read_strobe = 1'b0; interrupt_ack = 1'b0; in_ports = '0; irq_req = '0;
    tick(2);
    sysreset = 1'b0; write_strobe = 1'b0;
    exp_out = '0;
    check_eq("reset_out_ports", out_ports, exp_out);
    check_eq("reset_io_data_out", {120'd0, io_data_out}, 128'h0);
    check_eq("reset_interrupt", {127'd0, interrupt}, 128'h0);
    tick(3);

    in_ports[3*8 +: 8] = 8'hA5;
    in_ports[0 +: 8]   = 8'h11;
    rd(8'h03);
    check_eq("read_in3", {120'd0, io_data_out}, 128'hA5);
    rd(8'h00);
    check_eq("read_in0", {120'd0, io_data_out}, 128'h11);
    rd(8'h40);
    check_eq("read_unmapped_40", {120'd0, io_data_out}, 128'h0);

    wr(8'h05, 8'h3C);
    exp_out[5*8 +: 8] = 8'h3C;
    check_eq("write_out5", out_ports, exp_out);
    wr(8'h20, 8'hEE);
    check_eq("write_ignored_20", out_ports, exp_out);

    wr(8'hFC, 8'h01);
    irq_req[1] = 1'b1;
    tick(3);
    irq_req[1] = 1'b0;
    rd(8'hFD);
    check_eq("pend_masked_src1", {120'd0, io_data_out}, 128'h02);
    check_eq("irq_masked_low", {127'd0, interrupt}, 128'h0);
    wr(8'hFC, 8'h03);
    check_eq("irq_on_mask_expose", {127'd0, interrupt}, 128'h1);
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    check_eq("irq_ack_clears", {127'd0, interrupt}, 128'h0);
    tick(2);
    check_eq("irq_stays_low_after_ack", {127'd0, interrupt}, 128'h0);
    wr(8'hFD, 8'h02);
    rd(8'hFD);
    check_eq("pend_w1c", {120'd0, io_data_out}, 128'h00);
    rd(8'hFC);
    check_eq("mask_read", {120'd0, io_data_out}, 128'h03);

    // edge on src0 reaches the pending register on the same edge as a W1C of bit 0
    irq_req[0] = 1'b1;
    tick(2);
    port_id = 8'hFD; io_data_in = 8'h01; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    rd(8'hFD);
    check_eq("pend_edge_beats_w1c", {120'd0, io_data_out}, 128'h01);
    check_eq("irq_from_src0", {127'd0, interrupt}, 128'h1);
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    wr(8'hFD, 8'h01);
    irq_req[0] = 1'b0;
    check_eq("irq_cleared_before_ack_collision", {127'd0, interrupt}, 128'h0);

    // new enabled edge lands on the same edge as an ack
    irq_req[1] = 1'b1;
    tick(2);
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    check_eq("irq_set_beats_ack", {127'd0, interrupt}, 128'h1);
    rd(8'hFE);
    check_eq("raw_level", {120'd0, io_data_out}, 128'h02);
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    wr(8'hFD, 8'h02);

    wr(8'h02, 8'h77);
    exp_out[2*8 +: 8] = 8'h77;
    check_eq("write_out2", out_ports, exp_out);
`ifdef KCPSM_IO_READBACK_EN
    exp_rb = 8'h77;
`else
    exp_rb = 8'h00;
`endif
    rd(8'h82);
    check_eq("readback_82", {120'd0, io_data_out}, {120'd0, exp_rb});

    // reset mid-operation with irq_req[1] still held high and a concurrent write
    sysreset = 1'b1; port_id = 8'h05; io_data_in = 8'hAA; write_strobe = 1'b1;
    tick(2);
    sysreset = 1'b0; write_strobe = 1'b0;
    exp_out = '0;
    check_eq("midreset_out_ports", out_ports, exp_out);
    check_eq("midreset_interrupt", {127'd0, interrupt}, 128'h0);
    tick(5);
    rd(8'hFD);
    check_eq("held_high_no_edge", {120'd0, io_data_out}, 128'h00);
    rd(8'hFC);
    check_eq("midreset_mask", {120'd0, io_data_out}, 128'h00);
    irq_req[1] = 1'b0;
    tick(3);
    irq_req[1] = 1'b1;
    tick(3);
    rd(8'hFD);
    check_eq("edge_after_release", {120'd0, io_data_out}, 128'h02);
    check_eq("masked_after_reset", {127'd0, interrupt}, 128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
